// File: rtl/avalon_aes_pkg.sv
// Shared types and register map for the Avalon-MM AES decrypt master.
package avalon_aes_pkg;

    // Transaction sequencer states, in the order a normal transaction visits them.
    typedef enum logic [2:0] {
        StIdle,
        StWrKey,
        StWrMsg,
        StWrGo,
        StPoll,
        StRdDec,
        StWrStop,
        StFin
    } state_e;

    // Slave register map (word addresses).
    localparam logic [3:0] ADDR_KEY0  = 4'd0;
    localparam logic [3:0] ADDR_MSG0  = 4'd4;
    localparam logic [3:0] ADDR_DEC0  = 4'd8;
    localparam logic [3:0] ADDR_START = 4'd14;
    localparam logic [3:0] ADDR_DONE  = 4'd15;

endpackage

// File: rtl/avalon_aes_master.sv
// Avalon-MM master driving an AES decrypt slave: loads key and message,
// starts the core, polls for completion, reads back the result and stops.
module avalon_aes_master
    import avalon_aes_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         START,
    input  logic [127:0] KEY_IN,
    input  logic [127:0] MSG_IN,
    output logic [127:0] DEC_OUT,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERROR,
    output logic         AVL_READ,
    output logic         AVL_WRITE,
    output logic         AVL_CS,
    output logic [3:0]   AVL_BYTE_EN,
    output logic [3:0]   AVL_ADDR,
    output logic [31:0]  AVL_WRITEDATA,
    input  logic [31:0]  AVL_READDATA
);

    // Poll counter value of the last permitted poll.
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    state_e        state_q, state_d;
    logic [1:0]    word_cnt_q, word_cnt_d;
    logic [15:0]   poll_cnt_q, poll_cnt_d;
    logic          timeout_q, timeout_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  msg_q, msg_d;
    logic [127:0]  dec_q, dec_d;
    logic [6:0]    word_lsb;

    // Bit offset of the 32-bit word selected by the word counter.
    assign word_lsb = {word_cnt_q, 5'd0};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            word_cnt_q <= 2'd0;
            poll_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
            key_q      <= 128'd0;
            msg_q      <= 128'd0;
            dec_q      <= 128'd0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
            key_q      <= key_d;
            msg_q      <= msg_d;
            dec_q      <= dec_d;
        end
    end

    // Next-state, datapath updates and bus/status outputs decoded from the state.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        timeout_d     = timeout_q;
        key_d         = key_q;
        msg_d         = msg_q;
        dec_d         = dec_q;
        AVL_READ      = 1'b0;
        AVL_WRITE     = 1'b0;
        AVL_ADDR      = 4'd0;
        AVL_WRITEDATA = 32'd0;
        DONE          = 1'b0;
        ERROR         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    key_d      = KEY_IN;
                    msg_d      = MSG_IN;
                    word_cnt_d = 2'd0;
                    poll_cnt_d = 16'd0;
                    timeout_d  = 1'b0;
                    state_d    = StWrKey;
                end
            end
            StWrKey: begin
                AVL_WRITE     = 1'b1;
                AVL_ADDR      = ADDR_KEY0 + {2'b00, word_cnt_q};
                AVL_WRITEDATA = key_q[word_lsb +: 32];
                word_cnt_d    = word_cnt_q + 2'd1;
                if (word_cnt_q == 2'd3) begin
                    state_d = StWrMsg;
                end
            end
            StWrMsg: begin
                AVL_WRITE     = 1'b1;
                AVL_ADDR      = ADDR_MSG0 + {2'b00, word_cnt_q};
                AVL_WRITEDATA = msg_q[word_lsb +: 32];
                word_cnt_d    = word_cnt_q + 2'd1;
                if (word_cnt_q == 2'd3) begin
                    state_d = StWrGo;
                end
            end
            StWrGo: begin
                AVL_WRITE     = 1'b1;
                AVL_ADDR      = ADDR_START;
                AVL_WRITEDATA = 32'h1;
                poll_cnt_d    = 16'd0;
                state_d       = StPoll;
            end
            StPoll: begin
                AVL_READ = 1'b1;
                AVL_ADDR = ADDR_DONE;
                if (AVL_READDATA[0]) begin
                    word_cnt_d = 2'd0;
                    state_d    = StRdDec;
                end else if (poll_cnt_q == POLL_LAST) begin
                    // Result registers are never read on timeout, so DEC_OUT keeps its value.
                    timeout_d = 1'b1;
                    state_d   = StWrStop;
                end else begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                end
            end
            StRdDec: begin
                AVL_READ                = 1'b1;
                AVL_ADDR                = ADDR_DEC0 + {2'b00, word_cnt_q};
                dec_d[word_lsb +: 32]   = AVL_READDATA;
                word_cnt_d              = word_cnt_q + 2'd1;
                if (word_cnt_q == 2'd3) begin
                    state_d = StWrStop;
                end
            end
            StWrStop: begin
                AVL_WRITE     = 1'b1;
                AVL_ADDR      = ADDR_START;
                AVL_WRITEDATA = 32'h0;
                state_d       = StFin;
            end
            StFin: begin
                DONE    = 1'b1;
                ERROR   = timeout_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign AVL_CS      = AVL_READ | AVL_WRITE;
    assign AVL_BYTE_EN = AVL_CS ? 4'hF : 4'h0;
    assign BUSY        = (state_q != StIdle);
    assign DEC_OUT     = dec_q;

endmodule

// File: tb/tb_avalon_aes_master.sv
// Directed bench for avalon_aes_master with a behavioural 16-register AES slave.
module tb_avalon_aes_master;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         START;
    logic [127:0] KEY_IN;
    logic [127:0] MSG_IN;
    logic [127:0] DEC_OUT;
    logic         BUSY, DONE, ERROR;
    logic         AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]   AVL_BYTE_EN, AVL_ADDR;
    logic [31:0]  AVL_WRITEDATA, AVL_READDATA;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    avalon_aes_master #(.POLL_LIMIT(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .START        (START),
        .KEY_IN       (KEY_IN),
        .MSG_IN       (MSG_IN),
        .DEC_OUT      (DEC_OUT),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERROR        (ERROR),
        .AVL_READ     (AVL_READ),
        .AVL_WRITE    (AVL_WRITE),
        .AVL_CS       (AVL_CS),
        .AVL_BYTE_EN  (AVL_BYTE_EN),
        .AVL_ADDR     (AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA (AVL_READDATA)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic [31:0] regs [16];
    int          done_cnt;
    logic        model_done_en = 1'b1;

    function automatic logic [31:0] preload(input logic [3:0] a);
        case (a)
            4'd8:    return 32'h11111111;
            4'd9:    return 32'h22222222;
            4'd10:   return 32'h33333333;
            4'd11:   return 32'h44444444;
            default: return 32'h0;
        endcase
    endfunction

    assign AVL_READDATA = !AVL_READ ? 32'h0 :
                          (AVL_ADDR >= 4'd8 && AVL_ADDR <= 4'd11) ? preload(AVL_ADDR) :
                          regs[AVL_ADDR];

    // Writes land on the edge ending the write cycle; DONE reg rises 3 edges after START=1.
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
            done_cnt <= 0;
        end else begin
            if (done_cnt != 0) begin
                done_cnt <= done_cnt - 1;
                if (done_cnt == 1 && model_done_en) regs[15] <= 32'h1;
            end
            if (AVL_WRITE) begin
                regs[AVL_ADDR] <= AVL_WRITEDATA;
                if (AVL_ADDR == 4'd14) begin
                    if (AVL_WRITEDATA[0]) begin
                        done_cnt <= 3;
                    end else begin
                        regs[15] <= 32'h0;
                        done_cnt <= 0;
                    end
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [3:0]  log_addr [256];
    logic        log_wr   [256];
    logic [31:0] log_data [256];
    int          log_cyc  [256];
    int          log_n = 0;
    int          done_cyc [64];
    logic        done_err [64];
    int          done_n = 0;
    int          proto_err = 0;

    always @(negedge Clk) begin
        if (AVL_CS === 1'b1 && log_n < 256) begin
            log_addr[log_n] = AVL_ADDR;
            log_wr[log_n]   = AVL_WRITE;
            log_data[log_n] = AVL_WRITEDATA;
            log_cyc[log_n]  = cyc;
            log_n++;
        end
        if (AVL_CS !== (AVL_READ | AVL_WRITE)) proto_err++;
        if (AVL_READ === 1'b1 && AVL_WRITE === 1'b1) proto_err++;
        if (AVL_CS === 1'b1 && AVL_BYTE_EN !== 4'hF) proto_err++;
        if (AVL_CS === 1'b0 && {AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA} !== 40'd0) proto_err++;
        if (ERROR === 1'b1 && DONE !== 1'b1) proto_err++;
        if (DONE === 1'b1 && done_n < 64) begin
            done_cyc[done_n] = cyc;
            done_err[done_n] = ERROR;
            done_n++;
        end
    end

    task automatic clear_log;
        log_n     = 0;
        done_n    = 0;
        proto_err = 0;
    endtask

    // Pulses START for one sampling edge; returns the cycle of the first expected access.
    task automatic pulse_start(output int first_cyc);
        @(negedge Clk); #1;
        START     = 1'b1;
        first_cyc = cyc + 1;
        @(negedge Clk); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk); #1;
            if (done_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        Reset  = 1'b1;
        START  = 1'b0;
        KEY_IN = 128'h0;
        MSG_IN = 128'h0;
        repeat (3) @(negedge Clk);
        #1;
        tests_run++;
        if ({BUSY, DONE, ERROR, AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA}
            !== 46'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b cs=%b be=%h addr=%h wd=%h, want all 0",
                     BUSY, DONE, ERROR, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA);
        end
        tests_run++;
        if (DEC_OUT !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_dec_out: got %h want 0", DEC_OUT);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        tests_run++;
        if (BUSY !== 1'b0 || AVL_CS !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b cs=%b want 0 0", BUSY, AVL_CS);
        end
    endtask

    task automatic test_normal;
        logic [127:0] key, msg;
        logic [3:0]   ea [18];
        logic         ew [18];
        logic [31:0]  ed [18];
        int           s;
        bit           ok;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        msg = 128'hdae2f0d13c4b5a697887766554433221;
        for (int i = 0; i < 4; i++) begin
            ea[i] = 4'(i);      ew[i] = 1'b1; ed[i] = key[32*i +: 32];
            ea[4+i] = 4'(4+i);  ew[4+i] = 1'b1; ed[4+i] = msg[32*i +: 32];
            ea[9+i] = 4'd15;    ew[9+i] = 1'b0; ed[9+i] = 32'h0;
            ea[13+i] = 4'(8+i); ew[13+i] = 1'b0; ed[13+i] = 32'h0;
        end
        ea[8] = 4'd14;  ew[8] = 1'b1;  ed[8] = 32'h1;
        ea[17] = 4'd14; ew[17] = 1'b1; ed[17] = 32'h0;

        model_done_en = 1'b1;
        clear_log();
        KEY_IN = key;
        MSG_IN = msg;
        pulse_start(s);
        // The transaction must use the values latched with START.
        KEY_IN = '1;
        MSG_IN = '0;
        wait_done(1, 100, ok);

        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_done_seen: got no DONE within 100 cycles, want DONE");
        end
        tests_run++;
        if (log_n !== 18) begin
            tests_failed++;
            $display("FAIL normal_access_count: got %0d want 18", log_n);
        end
        tests_run++;
        if (log_cyc[0] !== s) begin
            tests_failed++;
            $display("FAIL normal_first_latency: got cycle %0d want %0d", log_cyc[0], s);
        end
        tests_run++;
        if (log_addr[0] !== 4'd0 || log_data[0] !== 32'h0c0d0e0f) begin
            tests_failed++;
            $display("FAIL normal_first_write: got addr %h data %h want 0 0c0d0e0f",
                     log_addr[0], log_data[0]);
        end
        for (int i = 0; i < 18; i++) begin
            tests_run++;
            if (log_addr[i] !== ea[i] || log_wr[i] !== ew[i] ||
                (ew[i] && log_data[i] !== ed[i]) || log_cyc[i] !== s + i) begin
                tests_failed++;
                $display("FAIL normal_access_%0d: got addr %h wr %b data %h cyc %0d want addr %h wr %b data %h cyc %0d",
                         i, log_addr[i], log_wr[i], log_data[i], log_cyc[i],
                         ea[i], ew[i], ed[i], s + i);
            end
        end
        tests_run++;
        if (done_cyc[0] !== s + 18 || done_err[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_done_timing: got cycle %0d err %b want cycle %0d err 0",
                     done_cyc[0], done_err[0], s + 18);
        end
        tests_run++;
        if (DEC_OUT !== 128'h44444444333333332222222211111111) begin
            tests_failed++;
            $display("FAIL normal_dec_out: got %h want 44444444333333332222222211111111", DEC_OUT);
        end
        tests_run++;
        if (proto_err !== 0) begin
            tests_failed++;
            $display("FAIL normal_protocol: got %0d violations want 0", proto_err);
        end
    endtask

    task automatic test_timeout;
        int s;
        int polls;
        bit ok;
        model_done_en = 1'b0;
        clear_log();
        KEY_IN = 128'hffeeddccbbaa99887766554433221100;
        MSG_IN = 128'h0123456789abcdef0123456789abcdef;
        pulse_start(s);
        wait_done(1, 100, ok);
        polls = 0;
        for (int i = 0; i < log_n; i++) begin
            if (log_addr[i] == 4'd15 && log_wr[i] == 1'b0) polls++;
        end
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_done_seen: got no DONE within 100 cycles, want DONE");
        end
        tests_run++;
        if (polls !== 8 || log_n !== 18) begin
            tests_failed++;
            $display("FAIL timeout_polls: got %0d polls %0d accesses want 8 polls 18 accesses",
                     polls, log_n);
        end
        tests_run++;
        if (log_addr[17] !== 4'd14 || log_wr[17] !== 1'b1 || log_data[17] !== 32'h0) begin
            tests_failed++;
            $display("FAIL timeout_stop_write: got addr %h wr %b data %h want addr e wr 1 data 0",
                     log_addr[17], log_wr[17], log_data[17]);
        end
        tests_run++;
        if (done_err[0] !== 1'b1 || done_cyc[0] !== s + 18) begin
            tests_failed++;
            $display("FAIL timeout_error: got err %b cycle %0d want err 1 cycle %0d",
                     done_err[0], done_cyc[0], s + 18);
        end
        tests_run++;
        if (DEC_OUT !== 128'h44444444333333332222222211111111) begin
            tests_failed++;
            $display("FAIL timeout_dec_hold: got %h want 44444444333333332222222211111111", DEC_OUT);
        end
        model_done_en = 1'b1;
    endtask

    task automatic test_start_ignored;
        int s;
        bit ok;
        bit in_poll;
        clear_log();
        pulse_start(s);
        in_poll = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk); #1;
            if (log_n > 0 && log_addr[log_n-1] == 4'd15 && log_wr[log_n-1] == 1'b0) begin
                in_poll = 1'b1;
                break;
            end
        end
        tests_run++;
        if (in_poll !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_reach_poll: got no poll within 50 cycles, want poll");
        end
        START = 1'b1;
        @(negedge Clk); #1;
        START = 1'b0;
        wait_done(1, 100, ok);
        repeat (30) @(negedge Clk);
        #1;
        tests_run++;
        if (done_n !== 1 || log_n !== 18) begin
            tests_failed++;
            $display("FAIL ignore_single_txn: got %0d DONE %0d accesses want 1 DONE 18 accesses",
                     done_n, log_n);
        end
        tests_run++;
        if (BUSY !== 1'b0 || done_err[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_final_state: got busy=%b err=%b want 0 0", BUSY, done_err[0]);
        end
    endtask

    task automatic test_back_to_back;
        int s;
        clear_log();
        @(negedge Clk); #1;
        START = 1'b1;
        s     = cyc + 1;
        repeat (40) @(negedge Clk);
        #1;
        START = 1'b0;
        repeat (30) @(negedge Clk);
        #1;
        tests_run++;
        if (done_n !== 2 || log_n !== 36) begin
            tests_failed++;
            $display("FAIL b2b_counts: got %0d DONE %0d accesses want 2 DONE 36 accesses",
                     done_n, log_n);
        end
        tests_run++;
        if (done_cyc[0] !== s + 18 || log_cyc[18] !== s + 20 || log_addr[18] !== 4'd0) begin
            tests_failed++;
            $display("FAIL b2b_relaunch: got done0 %0d second start %0d addr %h want %0d %0d 0",
                     done_cyc[0], log_cyc[18], log_addr[18], s + 18, s + 20);
        end
        tests_run++;
        if (done_cyc[1] !== s + 38 || done_err[0] !== 1'b0 || done_err[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_done: got cycle %0d errs %b%b want cycle %0d errs 00",
                     done_cyc[1], done_err[0], done_err[1], s + 38);
        end
        tests_run++;
        if (proto_err !== 0) begin
            tests_failed++;
            $display("FAIL b2b_protocol: got %0d violations want 0", proto_err);
        end
    endtask

    task automatic test_reset_mid;
        int s;
        int rc;
        int late;
        bit seen;
        clear_log();
        pulse_start(s);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (log_n > 0 && log_addr[log_n-1] == 4'd5) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk); #1;
        end
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_reach_msg: got no addr 5 write, want one");
        end
        Reset = 1'b1;
        rc    = cyc;
        @(negedge Clk); #1;
        tests_run++;
        if (AVL_CS !== 1'b0 || BUSY !== 1'b0 || DEC_OUT !== 128'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got cs=%b busy=%b dec=%h want 0 0 0",
                     AVL_CS, BUSY, DEC_OUT);
        end
        Reset = 1'b0;
        repeat (40) @(negedge Clk);
        #1;
        late = 0;
        for (int i = 0; i < log_n; i++) begin
            if (log_cyc[i] > rc) late++;
        end
        tests_run++;
        if (done_n !== 0 || late !== 0) begin
            tests_failed++;
            $display("FAIL midreset_abort: got %0d DONE %0d later accesses want 0 0", done_n, late);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/avalon_aes_master.md
AVALON_AES_MASTER -- requirements
Module: avalon_aes_master

Interface
REQ-001 SHALL have parameter: POLL_LIMIT, 1024, maximum DONE-register polls (addr 15) before timeout; legal range 1..65535.
REQ-002 SHALL have port: Clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: START  input  1  request one decrypt transaction; sampled only in IDLE.
REQ-005 SHALL have port: KEY_IN  input  128  AES key; word k = bits [32k+31:32k].
REQ-006 SHALL have port: MSG_IN  input  128  encrypted message; same word ordering.
REQ-007 SHALL have port: DEC_OUT  output  128  decrypted message read back; same word ordering.
REQ-008 SHALL have port: BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port: DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: ERROR  output  1  valid with DONE; 1 = poll timeout.
REQ-011 SHALL have ports (Avalon-MM master): AVL_READ out 1, AVL_WRITE out 1, AVL_CS out 1, AVL_BYTE_EN out 4, AVL_ADDR out 4, AVL_WRITEDATA out 32, AVL_READDATA in 32.

Function
REQ-012 SHALL latch KEY_IN and MSG_IN on the edge where START=1 in IDLE; later input changes do not affect the transaction.
REQ-013 SHALL ignore START while BUSY=1.
REQ-014 SHALL perform at most one bus access per cycle; AVL_CS=1 exactly when AVL_READ or AVL_WRITE=1; AVL_READ and AVL_WRITE never both 1.
REQ-015 SHALL drive AVL_BYTE_EN=4'b1111 on every access, and 0 when idle.
REQ-016 SHALL drive AVL_ADDR, AVL_WRITEDATA=0 when no access is in progress.
REQ-017 SHALL treat the slave as zero-wait, zero-latency: AVL_READDATA is sampled on the clock edge that ends the read cycle.
REQ-018 SHALL sequence states IDLE -> WR_KEY -> WR_MSG -> WR_GO -> POLL -> RD_DEC -> WR_STOP -> FIN -> IDLE.
REQ-019 WR_KEY: 4 consecutive writes, addr 0..3, data key word 0..3.
REQ-020 WR_MSG: 4 consecutive writes, addr 4..7, data msg word 0..3.
REQ-021 WR_GO: one write, addr 14, data 32'h1.
REQ-022 POLL: one read of addr 15 per cycle; exit to RD_DEC after a read with bit 0 = 1; other bits ignored.
REQ-023 SHALL count polls with a 16-bit counter; if POLL_LIMIT reads all return bit 0 = 0, SHALL go to WR_STOP with timeout flag set.
REQ-024 RD_DEC: 4 consecutive reads, addr 8..11; read word k loads DEC_OUT[32k+31:32k].
REQ-025 WR_STOP: one write, addr 14, data 32'h0, in both normal and timeout paths.
REQ-026 FIN: DONE=1 for exactly one cycle, ERROR=timeout flag during that cycle, BUSY=1; next state IDLE.
REQ-027 Latency: with N polls (1<=N<=POLL_LIMIT), the first access is in the cycle after START is sampled; 14+N access cycles follow back-to-back; DONE is asserted in the next cycle.
REQ-028 On timeout, DEC_OUT SHALL keep its previous value and RD_DEC SHALL be skipped.
REQ-029 DEC_OUT SHALL hold its value until overwritten by the next successful RD_DEC.
REQ-030 ERROR SHALL be 0 whenever DONE=0.
REQ-031 START held high continuously SHALL launch a new transaction on the first IDLE cycle after FIN.

Reset
REQ-032 Reset SHALL force IDLE, clear the word and poll counters, the timeout flag and the latched key/message, and drive every output to 0, including DEC_OUT.
REQ-033 Reset mid-transaction SHALL abort with no further bus access from the next cycle, and SHALL not pulse DONE.

Structure
REQ-034 Package avalon_aes_pkg SHALL hold the state enum and the address constants ADDR_KEY0=0, ADDR_MSG0=4, ADDR_DEC0=8, ADDR_START=14, ADDR_DONE=15.
REQ-035 SHALL be a single module with no sub-module: one FSM, a 2-bit word counter and a 16-bit poll counter.

Verification
REQ-036 Bench SHALL use a behavioural model of the 16-register slave, with DONE set 3 cycles after a 1 is written to START.
REQ-037 Bench: KEY_IN=128'h000102030405060708090a0b0c0d0e0f, MSG_IN=128'hdae2...(any), START pulse -> exactly 18 accesses are observed; first write is addr 0, data 32'h0c0d0e0f; DONE=1 and ERROR=0 are asserted in the cycle after the last access.
REQ-038 Bench: model preloads regs 8..11 = 32'h11111111, 22222222, 33333333, 44444444 -> DEC_OUT=128'h44444444333333332222222211111111.
REQ-039 Bench: POLL_LIMIT=8, model never sets DONE -> 8 reads of addr 15, then a write of 0 to addr 14; DONE=1 and ERROR=1 are asserted; DEC_OUT is unchanged.
REQ-040 Bench: START pulsed during POLL -> ignored; exactly one DONE pulse is produced.
REQ-041 Bench: Reset asserted during WR_MSG -> next cycle AVL_CS=0, BUSY=0, DEC_OUT=0, and no DONE pulse is produced.
REQ-042 Bench: START held high for 40 cycles -> two back-to-back transactions with no bus overlap.
